// File: rtl/jericalla_pkg.sv
// rtl/jericalla_pkg.sv - opcode encoding and decode helpers for the jericalla pipeline
package jericalla_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MIN = 3'd3,
    OP_LI  = 3'd4,
    OP_OR  = 3'd5,
    OP_SW  = 3'd6,
    OP_LW  = 3'd7
  } op_e;

  function automatic op_e op_of(input logic [OP_W-1:0] bits);
    return op_e'(bits);
  endfunction

  function automatic logic writes_reg(input op_e op);
    return !(op == OP_NOP || op == OP_SW);
  endfunction

  function automatic logic uses_rs(input op_e op);
    return op inside {OP_ADD, OP_SUB, OP_MIN, OP_OR, OP_SW, OP_LW};
  endfunction

  function automatic logic uses_rt(input op_e op);
    return op inside {OP_ADD, OP_SUB, OP_MIN, OP_OR, OP_SW};
  endfunction

endpackage

// File: rtl/jericalla_regfile.sv
// rtl/jericalla_regfile.sv - 2-read/1-write register file, register 0 hardwired to zero
module jericalla_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data
);

  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  logic [DATA_W-1:0] regs_d [2**ADDR_W];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[w_addr] = w_data;
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) regs_q <= '{default: '0};
    else          regs_q <= regs_d;
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/jericalla_pipe.sv
// rtl/jericalla_pipe.sv - 3-stage datapath core: decode/read, execute/memory, writeback
module jericalla_pipe
  import jericalla_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 6,
  localparam int INSTR_W   = 3 + 3 * REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     mem_rdata
);

  localparam int RA = REG_ADDR_W;

  typedef struct packed {
    logic          valid;
    op_e           op;
    logic [RA-1:0] rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } s2_t;

  logic               s1_valid_q, s1_valid_d;
  logic [INSTR_W-1:0] s1_instr_q, s1_instr_d;
  s2_t                s2_q, s2_d;
  logic               wb_valid_q, wb_valid_d;
  logic [RA-1:0]      wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0]  mem_q [2**MEM_ADDR_W];

  op_e               s1_op;
  logic [RA-1:0]     s1_rd, s1_rs, s1_rt;
  logic [DATA_W-1:0] rf_a, rf_b, opa, opb, alu_res, mem_rd;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic              s2_fwd, s3_fwd, load_use, mem_we;

  assign s1_op = op_of(s1_instr_q[INSTR_W-1 -: 3]);
  assign s1_rd = s1_instr_q[3*RA-1 -: RA];
  assign s1_rs = s1_instr_q[2*RA-1 -: RA];
  assign s1_rt = s1_instr_q[RA-1:0];

  jericalla_regfile #(.DATA_W(DATA_W), .ADDR_W(RA)) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .ra_addr (s1_rs),
    .rb_addr (s1_rt),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .we      (wb_valid_q),
    .w_addr  (wb_rd_q),
    .w_data  (wb_data_q)
  );

  // A load's data only exists at the end of S2, so it cannot feed S1 directly.
  assign s2_fwd = s2_q.valid && writes_reg(s2_q.op) && (s2_q.op != OP_LW) && (s2_q.rd != '0);
  assign s3_fwd = wb_valid_q && (wb_rd_q != '0);

  always_comb begin
    opa = rf_a;
    if (s2_fwd && s2_q.rd == s1_rs)      opa = alu_res;
    else if (s3_fwd && wb_rd_q == s1_rs) opa = wb_data_q;
    opb = rf_b;
    if (s2_fwd && s2_q.rd == s1_rt)      opb = alu_res;
    else if (s3_fwd && wb_rd_q == s1_rt) opb = wb_data_q;
  end

  assign load_use = s1_valid_q && s2_q.valid && (s2_q.op == OP_LW) && (s2_q.rd != '0) &&
                    ((uses_rs(s1_op) && s1_rs == s2_q.rd) || (uses_rt(s1_op) && s1_rt == s2_q.rd));
  assign instr_ready = !load_use;

  always_comb begin
    alu_res = '0;
    case (s2_q.op)
      OP_ADD:  alu_res = s2_q.a + s2_q.b;
      OP_SUB:  alu_res = s2_q.a - s2_q.b;
      OP_MIN:  alu_res = ($signed(s2_q.a) < $signed(s2_q.b)) ? s2_q.a : s2_q.b;
      OP_LI:   alu_res = s2_q.b;
      OP_OR:   alu_res = s2_q.a | s2_q.b;
      default: alu_res = '0;
    endcase
  end

  assign mem_addr = s2_q.a[MEM_ADDR_W-1:0];
  assign mem_rd   = mem_q[mem_addr];
  assign mem_we   = s2_q.valid && (s2_q.op == OP_SW);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s2_d       = '0;
    if (!load_use) begin
      s1_valid_d = instr_valid;
      if (instr_valid) s1_instr_d = instr;
      if (s1_valid_q) begin
        s2_d.valid = 1'b1;
        s2_d.op    = s1_op;
        s2_d.rd    = s1_rd;
        s2_d.a     = opa;
        // LI carries its immediate in the B operand so the ALU just passes it through.
        s2_d.b     = (s1_op == OP_LI) ? DATA_W'({s1_rs, s1_rt}) : opb;
      end
    end
    wb_valid_d  = s2_q.valid && writes_reg(s2_q.op);
    wb_rd_d     = s2_q.rd;
    wb_data_d   = (s2_q.op == OP_LW) ? mem_rd : alu_res;
    mem_rdata_d = (s2_q.valid && s2_q.op == OP_LW) ? mem_rd : mem_rdata_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_instr_q  <= '0;
      s2_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_instr_q  <= s1_instr_d;
      s2_q        <= s2_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // mem_we derives from the async-cleared S2 valid, so a reset edge never writes.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_addr] <= s2_q.b;
  end

  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_jericalla_pipe.sv
// tb/tb_jericalla_pipe.sv - directed self-checking bench for jericalla_pipe
module tb_jericalla_pipe;

  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, MIN = 3'd3,
                         LI = 3'd4, OR = 3'd5, SW = 3'd6, LW = 3'd7;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] mem_rdata;

  int asserts = 0;
  int errors = 0;
  int stall_cycles = 0;
  int          wbq_rd[$];
  logic [31:0] wbq_data[$];

  jericalla_pipe dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n) begin
      if (wb_valid) begin
        wbq_rd.push_back(int'(wb_rd));
        wbq_data.push_back(wb_data);
      end
      if (!instr_ready) stall_cycles++;
    end
  end

  task automatic clear_log();
    wbq_rd.delete();
    wbq_data.delete();
    stall_cycles = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] op, input int rd, input int rs, input int rt);
    int n;
    instr = {op, 5'(rd), 5'(rs), 5'(rt)};
    instr_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!instr_ready && n < 10) begin
      n++;
      @(negedge clock);
    end
    if (n == 10) begin
      errors++;
      $display("FAIL send_timeout: instr_ready stayed %0b, required 1", instr_ready);
    end
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr = '0;
  endtask

  task automatic test_reset();
    #12;
    asserts++;
    if ({wb_valid, wb_rd, wb_data, mem_rdata, instr_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_init: wb_valid=%0b rd=%0d data=%h mem_rdata=%h ready=%0b, required 0 0 0 0 1",
               wb_valid, wb_rd, wb_data, mem_rdata, instr_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    send(LI, 1, 0, 5);
    send(LI, 2, 0, 9);
    reset_n = 1'b0;
    #1;
    asserts++;
    if ({wb_valid, wb_rd, wb_data, mem_rdata, instr_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: wb_valid=%0b rd=%0d data=%h mem_rdata=%h ready=%0b, required 0 0 0 0 1",
               wb_valid, wb_rd, wb_data, mem_rdata, instr_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    clear_log();
  endtask

  task automatic test_back_to_back();
    int er[3] = '{1, 2, 3};
    logic [31:0] ed[3] = '{32'd5, 32'd3, 32'd8};
    clear_log();
    send(LI, 1, 0, 5);
    send(LI, 2, 0, 3);
    send(ADD, 3, 1, 2);
    idle(4);
    asserts++;
    if (wbq_rd.size() != 3 || stall_cycles != 0) begin
      errors++;
      $display("FAIL b2b_count: wb=%0d stalls=%0d, required 3 and 0", wbq_rd.size(), stall_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      asserts++;
      if (i >= wbq_rd.size() || wbq_rd[i] != er[i] || wbq_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL b2b_wb%0d: got rd=%0d data=%h, required rd=%0d data=%h", i,
                 (i < wbq_rd.size()) ? wbq_rd[i] : -1, (i < wbq_rd.size()) ? wbq_data[i] : 32'hx, er[i], ed[i]);
      end
    end
  endtask

  task automatic test_sub_min();
    int er[2] = '{4, 5};
    logic [31:0] ed[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE};
    clear_log();
    send(SUB, 4, 2, 1);
    send(MIN, 5, 4, 1);
    idle(4);
    asserts++;
    if (wbq_rd.size() != 2) begin
      errors++;
      $display("FAIL submin_count: wb=%0d, required 2", wbq_rd.size());
    end
    for (int i = 0; i < 2; i++) begin
      asserts++;
      if (i >= wbq_rd.size() || wbq_rd[i] != er[i] || wbq_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL submin_wb%0d: got rd=%0d data=%h, required rd=%0d data=%h", i,
                 (i < wbq_rd.size()) ? wbq_rd[i] : -1, (i < wbq_rd.size()) ? wbq_data[i] : 32'hx, er[i], ed[i]);
      end
    end
  endtask

  task automatic test_load_use();
    int er[2] = '{6, 7};
    logic [31:0] ed[2] = '{32'd8, 32'd16};
    clear_log();
    send(SW, 0, 1, 3);
    send(LW, 6, 1, 0);
    send(ADD, 7, 6, 6);
    idle(5);
    asserts++;
    if (stall_cycles != 1 || wbq_rd.size() != 2) begin
      errors++;
      $display("FAIL loaduse_stall: stalls=%0d wb=%0d, required 1 and 2", stall_cycles, wbq_rd.size());
    end
    for (int i = 0; i < 2; i++) begin
      asserts++;
      if (i >= wbq_rd.size() || wbq_rd[i] != er[i] || wbq_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL loaduse_wb%0d: got rd=%0d data=%h, required rd=%0d data=%h", i,
                 (i < wbq_rd.size()) ? wbq_rd[i] : -1, (i < wbq_rd.size()) ? wbq_data[i] : 32'hx, er[i], ed[i]);
      end
    end
    asserts++;
    if (mem_rdata !== 32'd8) begin
      errors++;
      $display("FAIL loaduse_rdata: got %h, required 00000008", mem_rdata);
    end
  endtask

  task automatic test_r0();
    int er[2] = '{0, 8};
    logic [31:0] ed[2] = '{32'd7, 32'd5};
    clear_log();
    send(LI, 0, 0, 7);
    send(OR, 8, 0, 1);
    idle(4);
    asserts++;
    if (wbq_rd.size() != 2) begin
      errors++;
      $display("FAIL r0_count: wb=%0d, required 2", wbq_rd.size());
    end
    for (int i = 0; i < 2; i++) begin
      asserts++;
      if (i >= wbq_rd.size() || wbq_rd[i] != er[i] || wbq_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL r0_wb%0d: got rd=%0d data=%h, required rd=%0d data=%h", i,
                 (i < wbq_rd.size()) ? wbq_rd[i] : -1, (i < wbq_rd.size()) ? wbq_data[i] : 32'hx, er[i], ed[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int er[2] = '{9, 10};
    logic [31:0] ed[2] = '{32'd69, 32'd5};
    clear_log();
    send(LI, 9, 2, 5);
    send(SW, 0, 9, 1);
    send(LW, 10, 1, 0);
    idle(4);
    asserts++;
    if (wbq_rd.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: wb=%0d, required 2", wbq_rd.size());
    end
    for (int i = 0; i < 2; i++) begin
      asserts++;
      if (i >= wbq_rd.size() || wbq_rd[i] != er[i] || wbq_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL wrap_wb%0d: got rd=%0d data=%h, required rd=%0d data=%h", i,
                 (i < wbq_rd.size()) ? wbq_rd[i] : -1, (i < wbq_rd.size()) ? wbq_data[i] : 32'hx, er[i], ed[i]);
      end
    end
    asserts++;
    if (mem_rdata !== 32'd5) begin
      errors++;
      $display("FAIL wrap_rdata: got %h, required 00000005", mem_rdata);
    end
  endtask

  task automatic test_reset_stall();
    int er[3] = '{13, 1, 2};
    logic [31:0] ed[3] = '{32'd0, 32'd5, 32'd5};
    clear_log();
    send(LW, 11, 1, 0);
    send(ADD, 12, 11, 11);
    asserts++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rststall_ready: got %0b, required 0", instr_ready);
    end
    reset_n = 1'b0;
    #1;
    asserts++;
    if (wb_valid !== 1'b0 || instr_ready !== 1'b1 || mem_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rststall_clear: wb_valid=%0b ready=%0b mem_rdata=%h, required 0 1 0",
               wb_valid, instr_ready, mem_rdata);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    clear_log();
    send(OR, 13, 1, 11);
    send(LI, 1, 0, 5);
    send(LW, 2, 1, 0);
    idle(4);
    asserts++;
    if (wbq_rd.size() != 3) begin
      errors++;
      $display("FAIL rststall_count: wb=%0d, required 3", wbq_rd.size());
    end
    for (int i = 0; i < 3; i++) begin
      asserts++;
      if (i >= wbq_rd.size() || wbq_rd[i] != er[i] || wbq_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL rststall_wb%0d: got rd=%0d data=%h, required rd=%0d data=%h", i,
                 (i < wbq_rd.size()) ? wbq_rd[i] : -1, (i < wbq_rd.size()) ? wbq_data[i] : 32'hx, er[i], ed[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sub_min();
    test_load_use();
    test_r0();
    test_wrap();
    test_reset_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation exceeded 20000 time units");
    $fatal(1);
  end

endmodule
